cdc_handshake_tx: RTL and testbench

Source-domain transmitter for a 4-phase req/ack bus crossing. It accepts a word over a valid/ready interface and holds it stable on `xfer_data`. It drives `xfer_req` and completes the 4-phase protocol against `xfer_ack_async`, which returns from the destination domain and passes through an internal 2-flop synchronizer. The partner block is the destination-side two-flop receiver, which synchronizes `xfer_req` and samples `xfer_data`.

---
 rtl/cdc_handshake_tx.sv | 128 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack clock-domain crossing.
// Accepts one word over valid/ready and holds it on xfer_data.
// Drives xfer_req through the full req/ack handshake against a synchronized ack.
// A sticky timeout flag reports a destination that stops responding.
module cdc_handshake_tx #(
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 xfer_req,
    output logic [BUS_WIDTH-1:0] xfer_data,
    input  logic                 xfer_ack_async,
    output logic                 done,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_t               state;
    logic                 ack_meta;
    logic                 ack_s;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] wait_cnt_inc;
    logic                 accept;
    logic                 leave_req;
    logic                 leave_rel;
    logic                 state_change;
    logic                 waiting;
    logic                 timeout_hit;

    // Two-flop synchronizer bringing the destination ack into clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= xfer_ack_async;
            ack_s    <= ack_meta;
        end
    end

    // Handshake decode: ready only in IDLE with no stale ack, plus state-change events
    always_comb begin
        in_ready     = rst_n && (state == S_IDLE) && !ack_s;
        accept       = in_valid && in_ready;
        leave_req    = (state == S_REQ) && ack_s;
        leave_rel    = (state == S_RELEASE) && !ack_s;
        state_change = accept || leave_req || leave_rel;
        waiting      = (state == S_REQ) || (state == S_RELEASE);
        wait_cnt_inc = wait_cnt + CNT_WIDTH'(1);
        // Flag on the edge where the counter would step onto TIMEOUT_CYCLES.
        timeout_hit  = TIMEOUT_EN && waiting && !state_change &&
                       (wait_cnt != '1) && (wait_cnt_inc == TIMEOUT_VAL);
    end

    // 4-phase FSM with registered req, data and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_REQ;
                        xfer_req  <= 1'b1;
                        xfer_data <= in_data;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        state    <= S_RELEASE;
                        xfer_req <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!ack_s) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    xfer_req <= 1'b0;
                end
            endcase
        end
    end

    // Per-state wait counter: cleared on each transition, saturating while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_change) begin
            wait_cnt <= '0;
        end else if (waiting && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt_inc;
        end
    end

    // Sticky timeout flag; a simultaneous set beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx.
// A negedge monitor scoreboards accepted words against xfer_data at each done pulse.
// Per-scenario tasks check the cycle-level handshake timing inline.
module tb_cdc_handshake_tx;

    // Accept-to-accept spacing with an instant responder:
    // 3 REQ cycles (2-flop ack sync + decision), 3 RELEASE cycles, then 1 IDLE cycle.
    localparam int PERIOD = 7;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       xfer_req;
    logic [7:0] xfer_data;
    logic       xfer_ack_async;
    logic       done;
    logic       timeout_err;
    logic       err_clr;

    logic       auto_ack;
    logic       force_ack;

    int         n_cmp;
    int         n_err;
    int         edge_cnt;
    logic [7:0] sb[$];

    cdc_handshake_tx #(
        .BUS_WIDTH     (8),
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .xfer_req      (xfer_req),
        .xfer_data     (xfer_data),
        .xfer_ack_async(xfer_ack_async),
        .done          (done),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    // Instant responder mirrors req back as ack; otherwise ack is forced by the tasks.
    assign xfer_ack_async = auto_ack ? xfer_req : force_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard monitor: push on accept, pop and compare on done.
    always @(negedge clk) begin
        logic [7:0] exp_word;
        #1;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_done: done pulse with empty scoreboard, xfer_data=%h", xfer_data);
                end else begin
                    exp_word = sb.pop_front();
                    if (xfer_data !== exp_word) begin
                        n_err++;
                        $display("FAIL sb_data: xfer_data=%h expected %h", xfer_data, exp_word);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(in_data);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({xfer_req, done, timeout_err, in_ready, xfer_data} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_vals: req/done/err/rdy/data=%b%b%b%b/%h expected 0000/00",
                     xfer_req, done, timeout_err, in_ready, xfer_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: in_ready=%b expected 1", in_ready);
        end
        // Start a transfer that never gets acked, then reset in the middle of it.
        in_valid = 1'b1;
        in_data  = 8'h5C;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (xfer_req !== 1'b1 || xfer_data !== 8'h5C) begin
            n_err++;
            $display("FAIL mid_req: req=%b data=%h expected 1/5c", xfer_req, xfer_data);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_err: timeout_err=%b expected 1", timeout_err);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({xfer_req, done, timeout_err, xfer_data} !== 11'h000) begin
            n_err++;
            $display("FAIL async_reset: req/done/err/data=%b%b%b/%h expected 000/00",
                     xfer_req, done, timeout_err, xfer_data);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_reset: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_rerelease: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        int n_edge;
        int j;
        auto_ack = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        n_edge   = edge_cnt + 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            j = edge_cnt - n_edge;
            n_cmp++;
            if (xfer_data !== 8'hA5) begin
                n_err++;
                $display("FAIL single_data: j=%0d xfer_data=%h expected a5", j, xfer_data);
            end
            n_cmp++;
            if (xfer_req !== (j <= 2)) begin
                n_err++;
                $display("FAIL single_req: j=%0d xfer_req=%b expected %b", j, xfer_req, (j <= 2));
            end
            n_cmp++;
            if (done !== (j == 6)) begin
                n_err++;
                $display("FAIL single_done: j=%0d done=%b expected %b", j, done, (j == 6));
            end
            n_cmp++;
            if (in_ready !== (j >= 6)) begin
                n_err++;
                $display("FAIL single_ready: j=%0d in_ready=%b expected %b", j, in_ready, (j >= 6));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int         acc [3];
        int         idx;
        int         dones;
        vals  = '{8'h01, 8'h02, 8'h03};
        acc   = '{0, 0, 0};
        idx   = 0;
        dones = 0;
        auto_ack = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            n_cmp++;
            if (in_ready === 1'b1 && xfer_req !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_busy: in_ready=1 while xfer_req=%b", xfer_req);
            end
            in_valid = (idx < 3);
            if (idx < 3) in_data = vals[idx];
            if (in_valid && in_ready) begin
                acc[idx] = edge_cnt + 1;
                idx++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (idx != 3) begin
            n_err++;
            $display("FAIL b2b_accepts: accepted=%0d expected 3", idx);
        end
        n_cmp++;
        if (dones != 3) begin
            n_err++;
            $display("FAIL b2b_dones: done pulses=%0d expected 3", dones);
        end
        n_cmp++;
        if (acc[1] - acc[0] != PERIOD || acc[2] - acc[1] != PERIOD) begin
            n_err++;
            $display("FAIL b2b_spacing: gaps=%0d,%0d expected %0d,%0d",
                     acc[1] - acc[0], acc[2] - acc[1], PERIOD, PERIOD);
        end
    endtask

    task automatic test_data_held();
        int         n_edge;
        int         j;
        int         waited;
        logic [7:0] r;
        auto_ack = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        n_edge   = edge_cnt + 1;
        r        = 8'h00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            j = edge_cnt - n_edge;
            n_cmp++;
            if (xfer_data !== 8'h3C) begin
                n_err++;
                $display("FAIL held_data: j=%0d xfer_data=%h expected 3c", j, xfer_data);
            end
            if (j == 6) begin
                n_cmp++;
                if (done !== 1'b1 || in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL held_done: done=%b in_ready=%b expected 1/1", done, in_ready);
                end
            end
            in_data = 8'($urandom);
            r = in_data;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (xfer_data !== r || xfer_req !== 1'b1) begin
            n_err++;
            $display("FAIL held_next: xfer_data=%h req=%b expected %h/1", xfer_data, xfer_req, r);
        end
        waited = 0;
        while (done !== 1'b1 && waited < 15) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL held_finish: done=%b after %0d cycles expected 1", done, waited);
        end
    endtask

    task automatic test_timeout();
        int n_edge;
        int j;
        int waited;
        auto_ack  = 1'b0;
        force_ack = 1'b0;
        err_clr   = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h77;
        n_edge   = edge_cnt + 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            j = edge_cnt - n_edge;
            n_cmp++;
            if (timeout_err !== (j >= 4)) begin
                n_err++;
                $display("FAIL to_err: j=%0d timeout_err=%b expected %b", j, timeout_err, (j >= 4));
            end
            n_cmp++;
            if (xfer_req !== 1'b1) begin
                n_err++;
                $display("FAIL to_req: j=%0d xfer_req=%b expected 1", j, xfer_req);
            end
            if (j == 4) err_clr = 1'b0;
        end
        err_clr   = 1'b0;
        force_ack = 1'b1;
        waited = 0;
        while (xfer_req !== 1'b0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (xfer_req !== 1'b0) begin
            n_err++;
            $display("FAIL to_release: xfer_req=%b after %0d cycles expected 0", xfer_req, waited);
        end
        force_ack = 1'b0;
        waited = 0;
        while (done !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL to_done: done=%b after %0d cycles expected 1", done, waited);
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_err++;
            $display("FAIL to_sticky: timeout_err=%b expected 1", timeout_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL to_clear: timeout_err=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_stale_ack();
        int waited;
        auto_ack  = 1'b0;
        force_ack = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || xfer_req !== 1'b0) begin
                n_err++;
                $display("FAIL stale_block: in_ready=%b req=%b expected 0/0", in_ready, xfer_req);
            end
        end
        force_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stale_one: in_ready=%b one cycle after ack fall expected 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stale_two: in_ready=%b two cycles after ack fall expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        auto_ack = 1'b1;
        n_cmp++;
        if (xfer_req !== 1'b1 || xfer_data !== 8'h99) begin
            n_err++;
            $display("FAIL stale_accept: req=%b data=%h expected 1/99", xfer_req, xfer_data);
        end
        waited = 0;
        while (done !== 1'b1 && waited < 15) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL stale_finish: done=%b after %0d cycles expected 1", done, waited);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        edge_cnt  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        err_clr   = 1'b0;
        auto_ack  = 1'b0;
        force_ack = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_data_held();
        test_timeout();
        test_stale_ack();

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d words left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
